// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
//   PCINIT        : PC fetched first after reset
//   fetch_data_t  : {raw_instr, pc, valid} record handed to decode
//   fetch_entry_t : {raw_instr, pc} record stored in the instruction FIFO
//   align_word    : clears the two low address bits of a byte address
package fetch_unit_pkg;

  localparam logic [63:0] PCINIT = 64'h0000_0000_8000_0000;

  typedef struct packed {
    logic [31:0] raw_instr;
    logic [63:0] pc;
    logic        valid;
  } fetch_data_t;

  typedef struct packed {
    logic [31:0] raw_instr;
    logic [63:0] pc;
  } fetch_entry_t;

  function automatic logic [63:0] align_word(input logic [63:0] addr);
    return addr & ~64'h3;
  endfunction

endpackage

// File: rtl/fetch_unit_fifo_sync.sv
// fifo_sync: single-clock FIFO of DEPTH entries of type T.
// Ports:
//   clk, reset  : clock and synchronous active-high reset
//   push, din   : write din at the tail (ignored when full unless also popping)
//   pop, dout   : dout shows the head entry; pop removes it (ignored when empty)
//   flush       : empties the FIFO; a push or pop in the same cycle is ignored
//   full, empty : occupancy flags
//   count       : number of stored entries (0..DEPTH)
// DEPTH must be a power of two (at least 2) so the pointers wrap for free.
module fifo_sync #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [31:0],
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           push,
  input  logic           pop,
  input  logic           flush,
  input  T               din,
  output T               dout,
  output logic           full,
  output logic           empty,
  output logic [PTR_W:0] count
);

  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

  T                 mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH_CNT);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // A push into a full FIFO is accepted only when the head leaves in the
  // same cycle, so occupancy never exceeds DEPTH.
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && (!full || do_pop) && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset: stale contents are never visible because
  // the occupancy count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage of the 64-bit in-order pipeline.
// Owns the PC, issues one word fetch at a time on the instruction bus and
// queues returned words in a DEPTH-entry FIFO that feeds decode.
// Ports:
//   clk, reset                  : clock, synchronous active-high reset
//   ireq_valid/ireq_addr/ireq_ready : fetch request (valid/ready), word aligned
//   iresp_valid/iresp_data      : fetch response (valid only, one per request)
//   redirect_valid/redirect_pc  : flush and restart at redirect_pc (bits [1:0] ignored)
//   out_valid/out_ready/dataF   : decode-side handshake; dataF.valid == out_valid
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [63:0] RESET_PC = PCINIT,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        ireq_ready,
  input  logic        iresp_valid,
  input  logic [31:0] iresp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output fetch_data_t dataF
);

  localparam int             PTR_W     = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

  logic [63:0]  pc_q, pc_d;
  logic [63:0]  fetch_pc_q, fetch_pc_d;
  logic         inflight_q, inflight_d;
  logic         stale_q, stale_d;
  logic         reset_q;

  logic         req_fire;
  logic         resp_take;
  logic         fifo_push;
  logic         fifo_pop;
  logic         fifo_full;
  logic         fifo_empty;
  logic [PTR_W:0] fifo_count;
  fetch_entry_t fifo_din;
  fetch_entry_t fifo_dout;

  // One request at a time; the free-slot test reserves room for the word
  // that the outstanding request will return. reset_q holds issue off for
  // the first cycle after reset so the bus sees a clean start.
  assign ireq_valid = !reset && !reset_q && !inflight_q && !redirect_valid
                      && (fifo_count < DEPTH_CNT);
  assign ireq_addr  = align_word(pc_q);
  assign req_fire   = ireq_valid && ireq_ready;

  // A response is only meaningful while a request is outstanding.
  assign resp_take  = iresp_valid && inflight_q;

  // Words from before a redirect (stale, or arriving in the redirect cycle)
  // are dropped. The full term is unreachable given slot reservation.
  assign fifo_push  = resp_take && !stale_q && !redirect_valid && !fifo_full;
  assign fifo_pop   = out_valid && out_ready;
  assign fifo_din   = '{raw_instr: iresp_data, pc: fetch_pc_q};

  always_comb begin
    pc_d       = pc_q;
    fetch_pc_d = fetch_pc_q;
    inflight_d = inflight_q;
    stale_d    = stale_q;
    if (resp_take) begin
      inflight_d = 1'b0;
      stale_d    = 1'b0;
    end
    // Cannot coincide with resp_take: issue requires inflight_q == 0.
    if (req_fire) begin
      inflight_d = 1'b1;
      fetch_pc_d = pc_q;
      pc_d       = pc_q + 64'd4;
    end
    if (redirect_valid) begin
      pc_d = align_word(redirect_pc);
      // Mark the outstanding response for disposal unless it is landing
      // right now, in which case it is already being dropped above.
      if (inflight_q && !iresp_valid) begin
        stale_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      fetch_pc_q <= '0;
      inflight_q <= 1'b0;
      stale_q    <= 1'b0;
      reset_q    <= 1'b1;
    end else begin
      pc_q       <= pc_d;
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
      stale_q    <= stale_d;
      reset_q    <= 1'b0;
    end
  end

  fifo_sync #(
    .DEPTH (DEPTH),
    .T     (fetch_entry_t)
  ) u_ififo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (redirect_valid),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign out_valid = !fifo_empty;

  always_comb begin
    dataF = '0;
    if (!fifo_empty) begin
      dataF = '{raw_instr: fifo_dout.raw_instr, pc: fifo_dout.pc, valid: 1'b1};
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit. A driver process plays the bus,
// decode and execute; a monitor at the falling edge keeps a reference model
// (next expected PC, one outstanding request tagged with a redirect epoch,
// queue of words owed to decode) and compares every DUT output against it.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        ireq_ready = 1'b0;
  logic        iresp_valid = 1'b0;
  logic [31:0] iresp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  fetch_data_t dataF;

  fetch_unit #(.RESET_PC(PCINIT), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .ireq_valid     (ireq_valid),
    .ireq_addr      (ireq_addr),
    .ireq_ready     (ireq_ready),
    .iresp_valid    (iresp_valid),
    .iresp_data     (iresp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .dataF          (dataF)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int pops  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model state ----------------
  fetch_entry_t exp_q[$];
  fetch_entry_t e;
  logic [63:0]  model_pc = PCINIT;
  bit           pend = 0;
  logic [63:0]  pend_addr = '0;
  int           pend_epoch = 0;
  int           epoch = 0;
  bit           rst_seen = 1;
  bit           fire_evt = 0;

  always @(negedge clk) begin
    bit exp_irv;
    int sz0;
    exp_irv = !reset && !rst_seen && !pend && !redirect_valid && (exp_q.size() < DEPTH);
    chk("ireq_valid", {63'b0, ireq_valid}, {63'b0, exp_irv});
    if (ireq_valid && exp_irv) chk("ireq_addr", ireq_addr, model_pc);
    chk("out_valid", {63'b0, out_valid}, {63'b0, exp_q.size() != 0});
    chk("dataF.valid", {63'b0, dataF.valid}, {63'b0, out_valid});
    if (reset) begin
      exp_q.delete();
      pend     = 0;
      model_pc = PCINIT;
      epoch++;
      fire_evt = 0;
    end else begin
      sz0 = exp_q.size();
      chk("resp_without_request", {63'b0, iresp_valid && !pend}, 64'd0);
      if (out_valid && out_ready && !redirect_valid && sz0 != 0) begin
        e = exp_q.pop_front();
        chk("dataF.pc", dataF.pc, e.pc);
        chk("dataF.raw_instr", {32'b0, dataF.raw_instr}, {32'b0, e.raw_instr});
        pops++;
        $display("[TB] t=%0t decode took pc=%h instr=%h", $time, dataF.pc, dataF.raw_instr);
      end
      if (iresp_valid && pend) begin
        pend = 0;
        if (pend_epoch == epoch && !redirect_valid) begin
          chk("push_into_full", {63'b0, sz0 >= DEPTH}, 64'd0);
          exp_q.push_back('{raw_instr: iresp_data, pc: pend_addr});
        end
      end
      if (ireq_valid && ireq_ready) begin
        pend       = 1;
        pend_epoch = epoch;
        pend_addr  = model_pc;
        model_pc   = model_pc + 64'd4;
        fire_evt   = 1;
      end
      if (redirect_valid) begin
        exp_q.delete();
        epoch++;
        model_pc = redirect_pc & ~64'h3;
      end
    end
    rst_seen = reset;
  end

  // ---------------- driver ----------------
  int          rdy_pct = 100, ordy_pct = 100, redir_pct = 0, rst_pm = 0;
  int          dly_min = 0, dly_max = 0, rst_cycles = 0;
  bit          shot_busy = 0, shot_resp = 0, shot_now = 0;
  logic [63:0] shot_pc = '0;
  bit          bus_busy = 0;
  int          bus_dly = 0;
  logic [31:0] bus_data = '0;

  function automatic bit pct(input int p);
    return $urandom_range(99, 0) < p;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    if (fire_evt) begin
      fire_evt = 0;
      bus_busy = 1;
      bus_dly  = $urandom_range(dly_max, dly_min);
      bus_data = $urandom;
    end
    iresp_valid = 1'b0;
    iresp_data  = $urandom;
    if (bus_busy) begin
      if (bus_dly == 0) begin
        iresp_valid = 1'b1;
        iresp_data  = bus_data;
        bus_busy    = 0;
      end else begin
        bus_dly--;
      end
    end
    ireq_ready     = pct(rdy_pct);
    out_ready      = pct(ordy_pct);
    redirect_valid = 1'b0;
    redirect_pc    = {$urandom, $urandom};
    if (redir_pct != 0 && pct(redir_pct)) redirect_valid = 1'b1;
    if (shot_busy && bus_busy && !iresp_valid) begin
      redirect_valid = 1'b1; redirect_pc = shot_pc; shot_busy = 0;
    end
    if (shot_resp && iresp_valid) begin
      redirect_valid = 1'b1; redirect_pc = shot_pc; out_ready = 1'b1; shot_resp = 0;
    end
    if (shot_now) begin
      redirect_valid = 1'b1; redirect_pc = shot_pc; shot_now = 0;
    end
    reset = 1'b0;
    if (rst_cycles > 0) begin
      reset = 1'b1;
      rst_cycles--;
    end else if (rst_pm != 0 && $urandom_range(999, 0) < rst_pm) begin
      reset = 1'b1;
    end
    if (reset) begin
      bus_busy    = 0;
      iresp_valid = 1'b0;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    // Reset, then zero-wait bus with decode always ready.
    rst_cycles = 3;
    run(3);
    pops = 0;
    run(30);
    @(negedge clk); #1;
    chk("throughput_pops_in_30", pops, 14);

    // Decode stalls: FIFO fills to DEPTH and issue stops.
    ordy_pct = 0;
    run(20);
    @(negedge clk); #1;
    chk("stall_ireq_valid", {63'b0, ireq_valid}, 64'd0);
    chk("stall_out_valid", {63'b0, out_valid}, 64'd1);
    ordy_pct = 100;
    run(30);

    // Bus not ready for 3 cycles right after reset.
    rst_cycles = 1;
    run(1);
    rdy_pct = 0;
    run(4);
    rdy_pct = 100;
    run(12);

    // Redirect while a response is outstanding, response 2 cycles later.
    dly_min = 2; dly_max = 2;
    shot_pc = 64'h0000_0000_8000_1002;
    shot_busy = 1;
    run(24);

    // Redirect coinciding with a response and a pop.
    dly_min = 0; dly_max = 0; ordy_pct = 50;
    shot_pc = 64'h0000_0000_8000_2000;
    shot_resp = 1;
    run(24);

    // Reset in the middle of a stall with a request outstanding.
    ordy_pct = 0; dly_min = 6; dly_max = 6;
    run(20);
    rst_cycles = 1;
    run(1);
    ordy_pct = 100; dly_min = 0; dly_max = 0;
    run(15);

    // PC wrap at the top of the address space.
    shot_pc = 64'hFFFF_FFFF_FFFF_FFFA;
    shot_now = 1;
    run(20);

    // Random traffic with redirects and occasional resets.
    rdy_pct = 70; ordy_pct = 60; dly_min = 0; dly_max = 4;
    redir_pct = 5; rst_pm = 3;
    run(3000);

    // Quiet drain.
    redir_pct = 0; rst_pm = 0; ordy_pct = 100; rdy_pct = 100;
    run(30);
    @(negedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
